// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StSub,
      StSubAck,
      StWdata,
      StWdataAck,
      StRdata,
      StRack,
      StIgnore
   } state_e;

   localparam logic       AckBit         = 1'b0;
   localparam logic       NakBit         = 1'b1;
   localparam logic [6:0] I2cAddrDefault = 7'h38;

endpackage

// File: rtl/i2c_reg_slave_if.sv
// Pin and register-port bundle between the I2C target and the core/pads.
interface i2c_reg_slave_if #(
   parameter int unsigned RegAw = 4
);
   logic             scl_in;
   logic             sda_in;
   logic             sda_oe;
   logic             wr_en;
   logic [RegAw-1:0] wr_addr;
   logic [7:0]       wr_data;
   logic [RegAw-1:0] rd_addr;
   logic [7:0]       rd_data;
   logic             busy;

   modport slave (
      input  scl_in, sda_in, rd_data,
      output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
   );

   modport master (
      output scl_in, sda_in, rd_data,
      input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
   );
endinterface

// File: rtl/i2c_sync_filter.sv
// Two-flop synchronizer plus stable-run glitch filter for one open-drain line.
// Emits the filtered level and single-cycle rise/fall pulses.
module i2c_sync_filter #(
   parameter int unsigned Filt = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [1:0]      sync_q;
   logic [Filt-1:0] hist_q;
   logic            level_q;
   logic            prev_q;

   // Idle bus is high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         hist_q  <= '1;
         level_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], pin};
         hist_q <= (hist_q << 1) | Filt'(sync_q[1]);
         if (&hist_q) begin
            level_q <= 1'b1;
         end else if (~|hist_q) begin
            level_q <= 1'b0;
         end
         prev_q <= level_q;
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;
   assign fall  = ~level_q & prev_q;
endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target giving byte-wide access to a 2^RegAw register space with
// auto-incrementing sub-address for both writes and reads.
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  I2cAddr = I2cAddrDefault,
   parameter int unsigned RegAw   = 4,
   parameter int unsigned Filt    = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   i2c_reg_slave_if.slave bus
);
   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_sync_filter #(.Filt(Filt)) u_scl_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (bus.scl_in),
      .level(scl_lvl),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_sync_filter #(.Filt(Filt)) u_sda_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (bus.sda_in),
      .level(sda_lvl),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   state_e           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [RegAw-1:0] ptr_q, ptr_d;
   logic             sda_oe_q, sda_oe_d;
   logic             wr_en_q, wr_en_d;
   logic [RegAw-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;

   logic [7:0] byte_in;
   logic       start_cond, stop_cond, last_bit;

   assign byte_in    = {shift_q[6:0], sda_lvl};
   assign start_cond = sda_fall & scl_lvl;
   assign stop_cond  = sda_rise & scl_lvl;
   assign last_bit   = (bit_cnt_q == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         sda_oe_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (!ena || stop_cond) begin
         state_d  = StIdle;
         sda_oe_d = 1'b0;
      end else if (start_cond) begin
         state_d   = StAddr;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StAddr, StSub, StWdata: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     if (state_q == StAddr) begin
                        state_d = (byte_in[7:1] == I2cAddr) ? StAddrAck : StIgnore;
                     end else if (state_q == StSub) begin
                        ptr_d   = byte_in[RegAw-1:0];
                        state_d = StSubAck;
                     end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = byte_in;
                        ptr_d     = ptr_q + RegAw'(1);
                        state_d   = StWdataAck;
                     end
                  end
               end
            end
            // First SCL fall starts the ACK, the second one ends the 9th clock.
            StAddrAck, StSubAck, StWdataAck: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = ~AckBit;
                  end else if (state_q == StAddrAck && shift_q[0]) begin
                     shift_d  = bus.rd_data;
                     sda_oe_d = ~bus.rd_data[7];
                     state_d  = StRdata;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = (state_q == StAddrAck) ? StSub : StWdata;
                  end
               end
            end
            StRdata: begin
               if (scl_fall) begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     sda_oe_d = 1'b0;
                     state_d  = StRack;
                  end else begin
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            // bit_cnt doubles as the "controller ACKed" flag inside RACK.
            StRack: begin
               if (scl_rise) begin
                  if (sda_lvl == NakBit) begin
                     state_d = StIgnore;
                  end else begin
                     ptr_d     = ptr_q + RegAw'(1);
                     bit_cnt_d = 3'd1;
                  end
               end else if (scl_fall && bit_cnt_q == 3'd1) begin
                  shift_d   = bus.rd_data;
                  sda_oe_d  = ~bus.rd_data[7];
                  bit_cnt_d = '0;
                  state_d   = StRdata;
               end
            end
            StIgnore: ;
            default: begin
               state_d  = StIdle;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.sda_oe  = sda_oe_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.rd_addr = ptr_q;
   assign bus.busy    = !(state_q inside {StIdle, StAddr, StIgnore});
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: bit-banged I2C controller, register-file model and write/read scoreboards.
module tb_i2c_reg_slave;
   localparam int Q = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ena   = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic sda_line;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem [16];
   logic [11:0] wq[$];
   logic [7:0]  rq[$];
   logic [11:0] exp_w;
   logic        oe_forbid  = 1'b0;
   logic        oe_seen    = 1'b0;
   logic        wr_en_prev = 1'b0;

   i2c_reg_slave_if #(.RegAw(4)) bus ();

   assign sda_line    = sda_m & ~bus.sda_oe;
   assign bus.scl_in  = scl_m;
   assign bus.sda_in  = sda_line;
   assign bus.rd_data = mem[bus.rd_addr];

   i2c_reg_slave #(.I2cAddr(7'h38), .RegAw(4), .Filt(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write scoreboard and open-drain watch.
   always @(negedge clk) begin
      if (bus.wr_en) begin
         chk("wr_strobe_width", 32'(wr_en_prev), 32'd0);
         if (wq.size() == 0) begin
            chk("wr_unexpected", 32'({bus.wr_addr, bus.wr_data}), 32'hFFFF_FFFF);
         end else begin
            exp_w = wq.pop_front();
            chk("wr_addr_data", 32'({bus.wr_addr, bus.wr_data}), 32'(exp_w));
         end
      end
      if (oe_forbid && bus.sda_oe) oe_seen = 1'b1;
      wr_en_prev = bus.wr_en;
   end

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clock_bit(input logic b, output logic r);
      wait_q();
      sda_m = b;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      r = sda_line;
      wait_q();
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      wait_q();
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_q();
      sda_m = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      sda_m = 1'b1;
      wait_q();
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic r;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         clock_bit(1'b1, r);
         d = {d[6:0], r};
      end
      clock_bit(m_ack, r);
   endtask

   initial begin
      logic       ack;
      logic       r;
      logic [7:0] d;

      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7);
      mem[3] = 8'hA5;
      mem[4] = 8'h3C;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      rst_n = 1'b1;
      wait_q();

      // Two-byte write with auto-increment
      i2c_start();
      write_byte(8'h70, ack);
      chk("t1_addr_ack", 32'(ack), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      write_byte(8'h0A, ack);
      chk("t1_sub_ack", 32'(ack), 32'd0);
      wq.push_back({4'hA, 8'h55});
      write_byte(8'h55, ack);
      chk("t1_d0_ack", 32'(ack), 32'd0);
      wq.push_back({4'hB, 8'h1F});
      write_byte(8'h1F, ack);
      chk("t1_d1_ack", 32'(ack), 32'd0);
      i2c_stop();
      chk("t1_busy_after_stop", 32'(bus.busy), 32'd0);
      chk("t1_rd_addr", 32'(bus.rd_addr), 32'hC);
      chk("t1_writes_done", 32'(wq.size()), 32'd0);

      // Wrong address: no ACK, no drive, no write
      oe_forbid = 1'b1;
      oe_seen   = 1'b0;
      i2c_start();
      write_byte(8'h72, ack);
      chk("t2_addr_nak", 32'(ack), 32'd1);
      chk("t2_busy", 32'(bus.busy), 32'd0);
      write_byte(8'h0A, ack);
      chk("t2_sub_nak", 32'(ack), 32'd1);
      write_byte(8'h55, ack);
      chk("t2_data_nak", 32'(ack), 32'd1);
      i2c_stop();
      oe_forbid = 1'b0;
      chk("t2_oe_quiet", 32'(oe_seen), 32'd0);

      // Sub-address write, repeated START, two-byte read ending in NAK
      i2c_start();
      write_byte(8'h70, ack);
      chk("t3_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h03, ack);
      chk("t3_sub_ack", 32'(ack), 32'd0);
      i2c_start();
      write_byte(8'h71, ack);
      chk("t3_raddr_ack", 32'(ack), 32'd0);
      chk("t3_rd_addr0", 32'(bus.rd_addr), 32'd3);
      rq.push_back(8'hA5);
      read_byte(1'b0, d);
      chk("t3_rd_byte0", 32'(d), 32'(rq.pop_front()));
      chk("t3_rd_addr1", 32'(bus.rd_addr), 32'd4);
      rq.push_back(8'h3C);
      read_byte(1'b1, d);
      chk("t3_rd_byte1", 32'(d), 32'(rq.pop_front()));
      chk("t3_busy_ignore", 32'(bus.busy), 32'd0);
      oe_forbid = 1'b1;
      oe_seen   = 1'b0;
      write_byte(8'h00, ack);
      chk("t3_ignore_released", 32'(ack), 32'd1);
      i2c_stop();
      oe_forbid = 1'b0;
      chk("t3_oe_quiet", 32'(oe_seen), 32'd0);
      chk("t3_rd_addr_hold", 32'(bus.rd_addr), 32'd4);

      // Sub-address wrap 15 -> 0
      i2c_start();
      write_byte(8'h70, ack);
      chk("t4_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h0F, ack);
      chk("t4_sub_ack", 32'(ack), 32'd0);
      wq.push_back({4'hF, 8'h11});
      write_byte(8'h11, ack);
      chk("t4_d0_ack", 32'(ack), 32'd0);
      wq.push_back({4'h0, 8'h22});
      write_byte(8'h22, ack);
      chk("t4_d1_ack", 32'(ack), 32'd0);
      i2c_stop();
      chk("t4_writes_done", 32'(wq.size()), 32'd0);
      chk("t4_rd_addr_wrap", 32'(bus.rd_addr), 32'd1);

      // STOP mid-byte discards the partial byte, then a normal write
      i2c_start();
      write_byte(8'h70, ack);
      write_byte(8'h05, ack);
      for (int i = 0; i < 5; i++) clock_bit(1'b1, r);
      i2c_stop();
      chk("t5_busy_idle", 32'(bus.busy), 32'd0);
      chk("t5_rd_addr", 32'(bus.rd_addr), 32'd5);
      i2c_start();
      write_byte(8'h70, ack);
      chk("t5_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h06, ack);
      wq.push_back({4'h6, 8'h77});
      write_byte(8'h77, ack);
      chk("t5_d0_ack", 32'(ack), 32'd0);
      i2c_stop();
      chk("t5_writes_done", 32'(wq.size()), 32'd0);

      // Reset during the address ACK clock
      i2c_start();
      for (int i = 7; i >= 0; i--) clock_bit(d[i] ^ d[i] ^ ((8'h70 >> i) & 8'h1) != 0, r);
      wait_q();
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      chk("t6_ack_driven", 32'(bus.sda_oe), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      chk("t6_rst_busy", 32'(bus.busy), 32'd0);
      chk("t6_rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("t6_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("t6_rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("t6_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_q();
      scl_m = 1'b0;
      wait_q();
      i2c_start();
      write_byte(8'h70, ack);
      chk("t6_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h01, ack);
      wq.push_back({4'h1, 8'h99});
      write_byte(8'h99, ack);
      chk("t6_d0_ack", 32'(ack), 32'd0);
      i2c_stop();
      chk("t6_writes_done", 32'(wq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

I2C target (responder) that gives an external I2C controller byte-wide access to the dice design's configuration register space. It sits between the open-drain SDA/SCL pins on the bidirectional IO bus (SDA on uio[2], SCL on uio[3]) and the core's register decode. It samples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, and emits one write strobe per received data byte. It also serves reads from a combinational read port and auto-increments the sub-address.

## Interface
- I2C_ADDR, 7'h38, 7-bit device address (bus byte 0x70 write / 0x71 read)
- REG_AW, 4, sub-address width; register space is 2^REG_AW bytes
- FILT, 2, glitch-filter depth in clk cycles on synchronized SCL/SDA

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when 0, FSM held in IDLE, sda_oe=0
- scl_in  in  1  raw SCL pin (asynchronous)
- sda_in  in  1  raw SDA pin (asynchronous)
- sda_oe  out  1  1 = pull SDA low (top ties uio_out[2]=0, uio_oe[2]=sda_oe)
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  REG_AW  write sub-address
- wr_data  out  8  write data
- rd_addr  out  REG_AW  current read sub-address
- rd_data  in  8  register contents at rd_addr, combinational from core
- busy  out  1  1 from address match until STOP/START/NAK-exit

## Operation
- Front end: 2-flop synchronizer, then FILT-deep majority/stable filter, then registered previous value for edge detection.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Either condition has priority over bit processing in every state.
- START from any state, including a repeated START: go to ADDR, clear bit counter, release SDA.
- STOP from any state: go to IDLE, release SDA. A partially received byte is discarded with no wr_en.
- Data is sampled on SCL rising. The slave changes SDA only after SCL falling.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. On match of [7:1] go to ADDR_ACK; otherwise go to IGNORE (no ACK, wait for STOP/START).
  - ADDR_ACK: drive ACK for the 9th clock. If R/W=0, go to SUB. If R/W=1, load the shift register from rd_data and go to RDATA.
  - SUB: shift 8 bits and store the low REG_AW bits in ptr. Upper bits are ignored. Then go to SUB_ACK → WDATA.
  - WDATA: shift 8 bits. On the 8th rising edge, pulse wr_en with wr_addr=ptr and wr_data=byte. Then go to WDATA_ACK, ptr+=1 (mod 2^REG_AW, wraps 15→0), and return to WDATA.
  - RDATA: drive the shift register MSB after each SCL fall (sda_oe = ~bit). After 8 bits, go to RACK.
  - RACK: release SDA and sample the controller's ACK on SCL rise. ACK (0): ptr+=1, reload from rd_data, return to RDATA. NAK (1): go to IGNORE.
- rd_addr = ptr at all times.
- A write transaction's sub-address persists for a following repeated-START read.
- busy is 0 in IDLE and IGNORE.

## Timing
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0, state IDLE.
- Reset asserted mid-transaction takes effect immediately: sda_oe drops asynchronously.
- Pin-to-detect latency: 2 + FILT + 1 clk cycles. SCL high/low phases must exceed 2·(3+FILT) clk cycles.
- ACK: sda_oe rises within 1 clk after the filtered SCL fall following bit 8, and falls within 1 clk after the filtered SCL fall ending the 9th clock.
- wr_en: exactly 1 cycle, asserted 1 cycle after the filtered 8th SCL rise of a data byte. wr_addr/wr_data are valid in that cycle and held until the next strobe.
- rd_data is sampled in the cycle the shift register loads, i.e. 1 clk after the ACK clock ends (ADDR_ACK/RACK exit). The core must keep rd_data stable in that cycle.
- ena=0 mid-transaction: same as STOP.

## Structure
- Package i2c_pkg holds: state enum (IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE), the ACK/NAK bit constants, and the default I2C_ADDR.
- Sub-module i2c_sync_filter (one instance per line) outputs the filtered level plus rise/fall pulses. START/STOP/bit logic stays in i2c_reg_slave.

## Test plan
- Write 0x70, sub 0x0A, data 0x55, 0x1F, STOP → ACK on all 4 bytes. wr_en pulses twice: (0xA, 0x55), then (0xB, 0x1F). busy returns to 0 after STOP.
- Address 0x72 with data → no ACK on any byte, no wr_en, sda_oe stays 0.
- Write sub 0x03, repeated START, 0x71, core supplies 0xA5 then 0x3C; controller ACKs byte 1, NAKs byte 2 → SDA reads 0xA5, 0x3C; rd_addr 3→4. Then IGNORE; SDA is released and stays released until STOP.
- Sub 0x0F, data 0x11, 0x22 → writes (0xF, 0x11), then (0x0, 0x22) (wrap).
- STOP after 5 bits of a data byte → no wr_en, state IDLE. A following valid write works normally.
- rst_n low during an ACK clock → sda_oe=0 in the same cycle, all outputs at reset values. A next transaction with address 0x70 is ACKed.
